// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator that feeds the hardwired controller.
// It sequences the W1/W2/W3 beats with a per-beat t3 strobe and handles start, stop and single-step.
module beat_timing_gen #(
  parameter int PHASES = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             step,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             t3,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt
);
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);

  typedef enum logic [1:0] {B_W1, B_W2, B_W3} beat_e;

  beat_e            beat_q, beat_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ic_end;

  assign t3        = running_q && (phase_q == LAST_PH);
  assign w1        = (beat_q == B_W1);
  assign w2        = (beat_q == B_W2);
  assign w3        = (beat_q == B_W3);
  assign running   = running_q;
  assign cycle_cnt = cnt_q;

  always_comb begin
    beat_d    = beat_q;
    phase_d   = phase_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    ic_end    = 1'b0;
    if (!running_q) begin
      phase_d = '0;
      if (start) running_d = 1'b1;
    end else if (t3) begin
      // controller qualifiers only matter on the beat-ending edge
      phase_d = '0;
      unique case (beat_q)
        B_W1: if (short) ic_end = 1'b1; else beat_d = B_W2;
        B_W2: if (long) beat_d = B_W3; else begin beat_d = B_W1; ic_end = 1'b1; end
        default: begin beat_d = B_W1; ic_end = 1'b1; end
      endcase
      if (ic_end) cnt_d = cnt_q + 1'b1;
      if (stop || (step && ic_end)) running_d = 1'b0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      beat_q    <= B_W1;
      phase_q   <= '0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      beat_q    <= beat_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_beat_timing_gen.sv
// Self-checking bench for beat_timing_gen: directed table, corner sequences and random run vs a beat-level model.
module tb_beat_timing_gen;
  localparam int P = 3;

  logic clk = 1'b0;
  logic clr = 1'b0, start = 1'b0, step = 1'b0, short_i = 1'b0, long_i = 1'b0, stop_i = 1'b0;
  logic w1, w2, w3, t3, running;
  logic [7:0] cnt;
  logic sw1, sw2, sw3, st3, srun;
  logic [1:0] scnt;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  beat_timing_gen #(.PHASES(P), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .start(start), .step(step), .short(short_i), .long(long_i), .stop(stop_i),
    .w1(w1), .w2(w2), .w3(w3), .t3(t3), .running(running), .cycle_cnt(cnt));

  beat_timing_gen #(.PHASES(P), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .start(start), .step(step), .short(short_i), .long(long_i), .stop(stop_i),
    .w1(sw1), .w2(sw2), .w3(sw3), .t3(st3), .running(srun), .cycle_cnt(scnt));

  // model: beat number 1..3, clocks elapsed in the beat, completed cycles as a plain integer
  int  m_beat = 1, m_ph = 0, m_cnt = 0;
  bit  m_run = 0;

  task automatic model_step();
    int nb;
    if (clr) begin
      m_beat = 1; m_ph = 0; m_run = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_ph = 0;
      if (start) m_run = 1;
    end else if (m_ph == P - 1) begin
      nb = (m_beat == 1 && !short_i) ? 2 : (m_beat == 2 && long_i) ? 3 : 1;
      if (nb == 1) m_cnt = m_cnt + 1;
      if (stop_i || (step && nb == 1)) m_run = 0;
      m_beat = nb; m_ph = 0;
    end else begin
      m_ph = m_ph + 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("beat", {29'd0, w3, w2, w1}, 1 << (m_beat - 1));
    check("t3", int'(t3), int'(m_run && m_ph == P - 1));
    check("running", int'(running), int'(m_run));
    check("cnt", int'(cnt), m_cnt % 256);
    check("cnt2", int'(scnt), m_cnt % 4);
    check("onehot2", int'($countones({sw1, sw2, sw3})), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic c, s, sp, sh, lg, st);
    clr = c; start = s; step = sp; short_i = sh; long_i = lg; stop_i = st;
  endtask

  typedef struct {
    logic c, s, sp, sh, lg, st;
    logic ew1, ew2, ew3, et3, erun;
    int   ecnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic c, s, sp, sh, lg, st, ew1, ew2, ew3, et3, erun, input int ecnt);
    vec_t v;
    v.c = c; v.s = s; v.sp = sp; v.sh = sh; v.lg = lg; v.st = st;
    v.ew1 = ew1; v.ew2 = ew2; v.ew3 = ew3; v.et3 = et3; v.erun = erun; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    int n, c0;
    //            clr st sp sh lg sto  w1 w2 w3 t3 run cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0); // reset
    tbl[1]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0); // start
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0); // first t3, 3rd clock
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0); // W1 -> W2
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1); // stop in W2 t3
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1); // halted
    tbl[9]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1); // restart
    tbl[10] = mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1, 1); // short off-t3 ignored
    tbl[11] = mk(0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 1, 1);
    tbl[12] = mk(0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 1, 2); // short beats long
    tbl[13] = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 2); // start while running
    tbl[14] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2);
    tbl[15] = mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1, 2); // step, no cycle end

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].c, tbl[i].s, tbl[i].sp, tbl[i].sh, tbl[i].lg, tbl[i].st);
      tick();
      check($sformatf("vec%0d_beat", i), {29'd0, w3, w2, w1}, {29'd0, tbl[i].ew3, tbl[i].ew2, tbl[i].ew1});
      check($sformatf("vec%0d_t3", i), int'(t3), int'(tbl[i].et3));
      check($sformatf("vec%0d_run", i), int'(running), int'(tbl[i].erun));
      check($sformatf("vec%0d_cnt", i), int'(cnt), tbl[i].ecnt);
    end

    // stop in W2 t3, then 20 halted clocks with no strobes
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    while (!(m_beat == 2 && m_ph == P - 1) && n < 20) begin tick(); n++; end
    check("reach_w2t3", int'(t3 && w2), 1);
    stop_i = 1; tick(); stop_i = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_hold", {29'd0, t3, running, w1}, 1);
    end

    // single-step with long cycles: each start yields one 9-clock W1,W2,W3 cycle
    drive(0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      c0 = m_cnt;
      start = 1; tick(); start = 0;
      n = 0;
      while (running && n < 30) begin tick(); n++; end
      check("step_len", n, 3 * P);
      check("step_cnt", int'(cnt), (c0 + 1) % 256);
      check("step_w1", int'(w1), 1);
    end

    // clr during W3 phase 1 with cycle_cnt = 5
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 1, 0, 0); tick(); start = 0;
    n = 0;
    while (m_cnt < 5 && n < 40) begin tick(); n++; end
    check("cnt_at5", int'(cnt), 5);
    short_i = 0; long_i = 1;
    n = 0;
    while (!(m_beat == 3 && m_ph == 1) && n < 20) begin tick(); n++; end
    check("in_w3", int'(w3), 1);
    clr = 1; tick();
    check("clr_cnt", int'(cnt), 0);
    check("clr_state", {29'd0, running, t3, w1}, 1);
    start = 1; tick();
    check("clr_start", int'(running), 0);
    drive(0, 0, 0, 0, 0, 0);

    // random run against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 64) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
            ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
- Timing generator that sits directly upstream of the hardwired controller.
- Produces the one-hot beat signals w1/w2/w3 and the per-beat t3 strobe that the controller decodes.
- Consumes the controller's short, long and stop outputs to shorten, extend or halt the machine cycle.
- Start/stop front-end for the panel: a start pulse launches execution; stop or single-step mode halts it.

Parameters:
PHASES, 3, clock cycles per beat (t1..tN); t3 strobe in the last phase; legal range 2..16
CNT_W, 8, width of the completed-instruction-cycle counter

Ports:
clk  in  1  system clock
clr  in  1  reset; synchronous, active-high
start  in  1  one-cycle run request (debounced panel button)
step  in  1  single-step mode: auto-halt at end of every instruction cycle
short  in  1  from controller: end instruction cycle after W1
long  in  1  from controller: insert W3 after W2
stop  in  1  from controller: halt after current beat completes
w1  out  1  beat 1 active
w2  out  1  beat 2 active
w3  out  1  beat 3 active
t3  out  1  last-phase strobe of current beat; high one clock per beat while running
running  out  1  generator is advancing beats
cycle_cnt  out  CNT_W  completed instruction cycles, wrapping

Behaviour:
- Reset (clr=1 at clk edge; overrides every other input): w1=1, w2=0, w3=0, t3=0, running=0, phase=0, cycle_cnt=0.
- Exactly one of w1/w2/w3 is high at all times, including while halted.
- Phase counter: 0..PHASES-1, advances only while running=1.
- t3 is combinational: running && phase==PHASES-1.
- Halted (running=0): phase held at 0, beat held, t3=0.
  - start=1 -> running=1 next edge; first t3 arrives PHASES clocks after start is sampled.
  - start while running=1 is ignored.
- Beat transition on the edge that ends a t3 cycle; short/long/stop are sampled only in that cycle. Phase returns to 0.
  - W1: short=1 -> W1 (instruction cycle ends); else -> W2.
  - W2: long=1 -> W3; else -> W1 (instruction cycle ends).
  - W3 -> W1 (instruction cycle ends); short/long ignored.
  - short and long both high in W1: short wins. long in W1 and short in W2/W3 have no effect.
- Instruction cycle end: cycle_cnt increments by 1 on the same edge, wrapping from 2^CNT_W-1 to 0.
- Halt: running=0 on the transition edge if either of these holds:
  - stop=1 in the t3 cycle, or
  - step=1 and the transition ends an instruction cycle.
  The beat still advances normally on that edge, so a halt leaves the next beat (normally W1) displayed.
- start coinciding with a halting t3 edge is ignored: halt wins and a fresh start is required.
- clr mid-beat or mid-cycle aborts immediately to the reset state; no partial cycle_cnt update.
- No combinational path from short/long/stop to any output other than through registered state.

Test Plan:
- Reset then start, no short/long/stop -> t3 pulses every 3 clocks; beats W1,W2,W1,W2...; cycle_cnt +1 every 6 clocks; first t3 at 3rd clock after start.
- Hold short=1 for all beats -> W1 only, t3 every 3 clocks, cycle_cnt +1 per t3; with long=1 also held, short still wins.
- long=1 sampled in W2's t3 -> W1,W2,W3,W1; cycle_cnt +1 once per 9 clocks; long=1 in W1 alone does not create W3.
- stop=1 in W2's t3 -> running=0, w1=1, t3 stays 0 for 20 clocks; start -> resumes with W1, t3 after 3 clocks; start while running has no effect.
- step=1 with long cycles -> halts after each W3->W1 with cycle_cnt +1 per start; CNT_W=2 run -> cycle_cnt wraps 3->0.
- clr asserted during W3 phase 1 with cycle_cnt=5 -> next clock w1=1, running=0, cycle_cnt=0; clr and start together -> reset state, running=0.
